// File: rtl/fetch_addr_gen_if.sv
// AXI4 read-address and read-data signals seen by the instruction-fetch address generator.
// The master side issues AR bursts and monitors R beats; the slave side is the memory plus Ibits.
interface fetch_addr_gen_if #(
  parameter int ADDR_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic              rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst,
    input  arready, rvalid, rready, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst,
    output arready, rvalid, rready, rlast
  );
endinterface

// File: rtl/fetch_addr_gen.sv
// Instruction-fetch address generator: one AXI4 INCR read burst outstanding at a time,
// tracks the address of the current R beat and drains stale beats after a jump redirect.
module fetch_addr_gen #(
  parameter int                ADDR_W    = 32,
  parameter int                BURST_LEN = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  fetch_addr_gen_if.master   axi,
  input  logic               buf_full_i,
  input  logic               jump_i,
  input  logic [ADDR_W-1:0]  jump_target_i,
  output logic [ADDR_W-1:0]  fetch_pc_o,
  output logic               jump_wait_o,
  output logic               jump_accept_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic              pend_jump_q, pend_jump_d;
  logic              accept_q, accept_d;

  logic              beat;
  logic [ADDR_W-1:0] jump_tgt;
  logic [12:0]       words_to_4k;
  logic [12:0]       burst_words;
  logic [7:0]        arlen_calc;

  assign beat     = axi.rvalid & axi.rready;
  assign jump_tgt = jump_target_i & ~ADDR_W'(3);

  // Burst length is clipped so a burst never crosses a 4 KB boundary.
  always_comb begin
    words_to_4k = (13'd4096 - {1'b0, next_pc_q[11:0]}) >> 2;
    burst_words = (words_to_4k < 13'(BURST_LEN)) ? words_to_4k : 13'(BURST_LEN);
    arlen_calc  = 8'(burst_words - 13'd1);
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    next_pc_d   = next_pc_q;
    target_d    = target_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    pend_jump_d = pend_jump_q;
    accept_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (jump_i) begin
          next_pc_d = jump_tgt;
          accept_d  = 1'b1;
        end else if (!buf_full_i) begin
          araddr_d = next_pc_q;
          arlen_d  = arlen_calc;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (jump_i) begin
          target_d    = jump_tgt;
          pend_jump_d = 1'b1;
        end
        // The AR is never withdrawn; a jump here only decides where the beats go.
        if (axi.arready) begin
          fetch_pc_d  = araddr_q;
          pend_jump_d = 1'b0;
          state_d     = (pend_jump_q || jump_i) ? S_DRAIN : S_DATA;
        end
      end
      S_DATA: begin
        if (beat) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        if (jump_i) begin
          target_d = jump_tgt;
          if (beat && axi.rlast) begin
            next_pc_d = jump_tgt;
            accept_d  = 1'b1;
            state_d   = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (beat && axi.rlast) begin
          next_pc_d = fetch_pc_q + ADDR_W'(4);
          state_d   = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (jump_i) target_d = jump_tgt;
        if (beat) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
          if (axi.rlast) begin
            next_pc_d = jump_i ? jump_tgt : target_q;
            accept_d  = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      next_pc_q   <= RESET_PC;
      target_q    <= RESET_PC;
      araddr_q    <= RESET_PC;
      arlen_q     <= '0;
      pend_jump_q <= 1'b0;
      accept_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      next_pc_q   <= next_pc_d;
      target_q    <= target_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      pend_jump_q <= pend_jump_d;
      accept_q    <= accept_d;
    end
  end

  assign axi.arvalid   = (state_q == S_ADDR);
  assign axi.araddr    = araddr_q;
  assign axi.arlen     = arlen_q;
  assign axi.arsize    = 3'b010;
  assign axi.arburst   = 2'b01;
  assign fetch_pc_o    = fetch_pc_q;
  assign jump_wait_o   = (state_q == S_DRAIN) || pend_jump_q;
  assign jump_accept_o = accept_q;

endmodule

// File: tb/tb_fetch_addr_gen.sv
// Directed bench for fetch_addr_gen: hand-written burst/jump sequences plus a table of
// jump targets checking the 4 KB-clipped AR address and length.
module tb_fetch_addr_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        buf_full = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] fetch_pc;
  logic        jump_wait;
  logic        jump_accept;

  int total = 0;
  int bad   = 0;

  fetch_addr_gen_if #(.ADDR_W(32)) axi ();

  fetch_addr_gen #(.ADDR_W(32), .BURST_LEN(8), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .axi           (axi.master),
    .buf_full_i    (buf_full),
    .jump_i        (jump),
    .jump_target_i (jump_target),
    .fetch_pc_o    (fetch_pc),
    .jump_wait_o   (jump_wait),
    .jump_accept_o (jump_accept)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic [7:0]  exp_len;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic last);
    axi.rvalid = 1'b1;
    axi.rready = 1'b1;
    axi.rlast  = last;
    step();
    axi.rvalid = 1'b0;
    axi.rready = 1'b0;
    axi.rlast  = 1'b0;
  endtask

  task automatic ar_handshake();
    axi.arready = 1'b1;
    step();
    axi.arready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 8'd7};
    vecs[1] = '{32'h0000_0FFA, 32'h0000_0FF8, 8'd1};
    vecs[2] = '{32'h0000_0FFC, 32'h0000_0FFC, 8'd0};
    vecs[3] = '{32'h0000_0FE0, 32'h0000_0FE0, 8'd7};
    vecs[4] = '{32'h0000_0FE4, 32'h0000_0FE4, 8'd6};
    vecs[5] = '{32'h0000_0FF0, 32'h0000_0FF0, 8'd3};
    vecs[6] = '{32'h0000_1000, 32'h0000_1000, 8'd7};
    vecs[7] = '{32'h1234_5677, 32'h1234_5674, 8'd7};

    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rready  = 1'b0;
    axi.rlast   = 1'b0;

    // Reset state
    step();
    step();
    check("rst_arvalid", 32'(axi.arvalid), 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_jump_wait", 32'(jump_wait), 32'd0);
    check("rst_jump_accept", 32'(jump_accept), 32'd0);

    // First AR after reset, held while arready is low
    rst = 1'b0;
    step();
    check("ar0_valid", 32'(axi.arvalid), 32'd1);
    check("ar0_addr", axi.araddr, 32'h0);
    check("ar0_len", 32'(axi.arlen), 32'd7);
    check("ar0_size", 32'(axi.arsize), 32'd2);
    check("ar0_burst", 32'(axi.arburst), 32'd1);
    step();
    check("ar0_hold_valid", 32'(axi.arvalid), 32'd1);
    check("ar0_hold_addr", axi.araddr, 32'h0);
    ar_handshake();
    check("ar0_done", 32'(axi.arvalid), 32'd0);

    // Eight sequential beats; buffer fills at the last one
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b0_pc%0d", i), fetch_pc, 32'(4 * i));
      if (i == 7) buf_full = 1'b1;
      beat(i == 7);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_no_ar", 32'(axi.arvalid), 32'd0);
    end
    buf_full = 1'b0;
    step();
    check("ar1_valid", 32'(axi.arvalid), 32'd1);
    check("ar1_addr", axi.araddr, 32'h20);

    // Jump at beat 3 drains beats 4..7, then a single accept pulse and AR to target
    ar_handshake();
    for (int i = 0; i < 8; i++) begin
      if (i <= 3) check($sformatf("b1_pc%0d", i), fetch_pc, 32'h20 + 32'(4 * i));
      if (i == 3) begin
        jump = 1'b1;
        jump_target = 32'h100;
      end
      beat(i == 7);
      jump = 1'b0;
      if (i >= 3 && i < 7) check($sformatf("b1_wait%0d", i + 1), 32'(jump_wait), 32'd1);
    end
    check("j1_accept", 32'(jump_accept), 32'd1);
    check("j1_wait_clr", 32'(jump_wait), 32'd0);
    check("j1_no_ar", 32'(axi.arvalid), 32'd0);
    step();
    check("j1_accept_pulse", 32'(jump_accept), 32'd0);
    check("j1_ar_valid", 32'(axi.arvalid), 32'd1);
    check("j1_ar_addr", axi.araddr, 32'h100);
    ar_handshake();
    check("b2_pc0", fetch_pc, 32'h100);
    buf_full = 1'b1;
    for (int i = 0; i < 8; i++) beat(i == 7);

    // Jump to 0xFFA from IDLE: two-word burst up to the 4 KB line, then 0x1000
    jump = 1'b1;
    jump_target = 32'hFFA;
    step();
    jump = 1'b0;
    check("j2_accept", 32'(jump_accept), 32'd1);
    check("j2_no_wait", 32'(jump_wait), 32'd0);
    buf_full = 1'b0;
    step();
    check("j2_ar_addr", axi.araddr, 32'hFF8);
    check("j2_ar_len", 32'(axi.arlen), 32'd1);
    ar_handshake();
    check("b3_pc0", fetch_pc, 32'hFF8);
    beat(1'b0);
    check("b3_pc1", fetch_pc, 32'hFFC);
    beat(1'b1);
    check("b3_idle", 32'(axi.arvalid), 32'd0);
    step();
    check("ar4_valid", 32'(axi.arvalid), 32'd1);
    check("ar4_addr", axi.araddr, 32'h1000);
    check("ar4_len", 32'(axi.arlen), 32'd7);

    // Jump while the AR is stalled: AR held, whole burst drained, then AR to target
    jump = 1'b1;
    jump_target = 32'h2000;
    step();
    jump = 1'b0;
    check("j3_wait", 32'(jump_wait), 32'd1);
    check("j3_ar_held", 32'(axi.arvalid), 32'd1);
    check("j3_addr_held", axi.araddr, 32'h1000);
    step();
    check("j3_addr_held2", axi.araddr, 32'h1000);
    ar_handshake();
    check("j3_ar_done", 32'(axi.arvalid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("j3_drain%0d", i), 32'(jump_wait), 32'd1);
      check($sformatf("j3_no_acc%0d", i), 32'(jump_accept), 32'd0);
      beat(i == 7);
    end
    check("j3_accept", 32'(jump_accept), 32'd1);
    step();
    check("j3_ar_addr", axi.araddr, 32'h2000);
    check("j3_ar_valid", 32'(axi.arvalid), 32'd1);

    // Jump coinciding with the rlast beat: accept directly, no drain
    ar_handshake();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        jump = 1'b1;
        jump_target = 32'h300;
      end
      beat(i == 7);
      jump = 1'b0;
    end
    check("j4_no_wait", 32'(jump_wait), 32'd0);
    check("j4_accept", 32'(jump_accept), 32'd1);
    step();
    check("j4_ar_addr", axi.araddr, 32'h300);
    check("j4_ar_len", 32'(axi.arlen), 32'd7);

    // Reset in the middle of a burst
    ar_handshake();
    for (int i = 0; i < 3; i++) beat(1'b0);
    check("mid_pc", fetch_pc, 32'h30C);
    rst = 1'b1;
    buf_full = 1'b1;
    step();
    check("mrst_arvalid", 32'(axi.arvalid), 32'd0);
    check("mrst_fetch_pc", fetch_pc, 32'h0);
    check("mrst_wait", 32'(jump_wait), 32'd0);
    check("mrst_accept", 32'(jump_accept), 32'd0);
    rst = 1'b0;
    step();
    check("mrst_idle", 32'(axi.arvalid), 32'd0);

    // Table: jump from IDLE, then check the clipped AR and walk the burst
    for (int v = 0; v < 8; v++) begin
      jump = 1'b1;
      jump_target = vecs[v].target;
      step();
      jump = 1'b0;
      check($sformatf("t%0d_accept", v), 32'(jump_accept), 32'd1);
      buf_full = 1'b0;
      step();
      buf_full = 1'b1;
      check($sformatf("t%0d_valid", v), 32'(axi.arvalid), 32'd1);
      check($sformatf("t%0d_addr", v), axi.araddr, vecs[v].exp_addr);
      check($sformatf("t%0d_len", v), 32'(axi.arlen), 32'(vecs[v].exp_len));
      ar_handshake();
      check($sformatf("t%0d_pc0", v), fetch_pc, vecs[v].exp_addr);
      for (int i = 0; i <= int'(vecs[v].exp_len); i++) beat(i == int'(vecs[v].exp_len));
      check($sformatf("t%0d_pc_end", v), fetch_pc,
            vecs[v].exp_addr + 32'(4 * (int'(vecs[v].exp_len) + 1)));
      check($sformatf("t%0d_idle", v), 32'(axi.arvalid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
